rv_insn_encode: RTL and testbench
=================================

# rv_insn_encode

Turns structured encode requests (operation, register fields, immediate) into 32-bit RISC-V instruction words. Each request is range-checked, encoded and queued in a small FIFO. The FIFO drains into the fetch/decode boundary through a valid/ready handshake. Used for debug and monitor instruction injection and for self-test streams, and is the exact inverse of the front-end decode for the supported subset.

## Interface
Parameters:
- `LG_DEPTH`, default 2: log2 of FIFO depth (4 entries).

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `mode64` in 1: selects the RV64 shift-amount range and RV64 ops.
- `flush` in 1: synchronous queue clear.
- `in_valid` in 1: request valid.
- `in_ready` out 1: request accepted when `in_valid && in_ready`.
- `in_op` in `$bits(enc_op_t)`: operation.
- `in_rd`, `in_rs1`, `in_rs2` in 5 each: register fields.
- `in_imm` in 32: signed byte-offset or immediate value.
- `out_valid` out 1: instruction word available.
- `out_ready` in 1: consumer takes the word when `out_valid && out_ready`.
- `out_insn` out 32: encoded instruction.
- `enc_err` out 1: one-cycle pulse for a rejected request.
- `count` out `LG_DEPTH+1`: current occupancy.

## Operation
- Supported `enc_op_t`:
  - LUI, AUIPC (U-type)
  - ADDI, SLLI, SRLI, SRAI (I-type)
  - ADD, SUB (R-type)
  - LW, LD (I-type, opcode 0x03)
  - SW, SD (S-type)
  - BEQ, BNE (B-type)
  - JAL (J-type), JALR
  - EBREAK
  - RDCYCLE (CSRRS rd, 0xc00, x0)
- Range rules. A request that breaks any rule is illegal:
  - I/S-type: `in_imm` fits signed 12 bits.
  - B-type: fits signed 13 bits and `in_imm[0]`=0.
  - J-type: fits signed 21 bits and `in_imm[0]`=0.
  - U-type: `in_imm[11:0]`=0.
  - Shifts: `in_imm` in 0..63 when `mode64`, else 0..31.
  - LD and SD when `!mode64`.
- Fields not used by an op are forced to zero in the word; their input values are ignored.
- A legal accepted request is encoded combinationally and written to the FIFO tail in the acceptance cycle.
- An illegal accepted request is consumed but not written. `enc_err`=1 in the following cycle only.
- `in_ready` = `!full && !flush && !reset`. It does not depend on a same-cycle pop, so a full FIFO never accepts, even with `out_ready`=1.
- `out_valid` = `!empty`; `out_insn` = head entry, held stable while `out_valid && !out_ready`.
- Pointers are `LG_DEPTH+1` bits with a wrap bit.
  - full = equal indices with differing wrap bits.
  - empty = both equal.
- Push and pop in the same cycle (not full, not empty): `count` is unchanged and both pointers advance.

## Timing
- Reset values: `out_valid`=0, `enc_err`=0, `count`=0, pointers=0, `out_insn`=0 (entries are reset to zero).
- Latency: a word accepted in cycle N is at `out_insn` with `out_valid`=1 in cycle N+1 if the FIFO was empty.
- Throughput: 1 word per cycle sustained.
- `flush`:
  - Clears the pointers at the clock edge and suppresses any push in that cycle; a pop in the same cycle is a don't-care.
  - `out_valid`=0 the next cycle.
  - Any pending `enc_err` is still delivered.
- `reset` mid-stream: queued contents are discarded, all outputs take their reset values the next cycle, and `enc_err` is cleared.
- `reset` has priority over `flush`; `flush` has priority over push.

## Structure
- Shared package `rv_enc_pkg`:
  - `enc_op_t` enum, 5 bits.
  - Opcode constants: 0x03, 0x13, 0x17, 0x23, 0x33, 0x37, 0x63, 0x67, 0x6f, 0x73.
  - funct3/funct7 constants.
  - CSR number 0xc00.
- Natural sub-module: `rv_enc_core`, purely combinational, with inputs op, rd, rs1, rs2, imm, mode64 and outputs insn, illegal. The top holds the FIFO, pointers, `enc_err` flop and `count`.

## Test plan
- ADDI rd=1, rs1=0, imm=5 into empty FIFO with `out_ready`=1 → `out_insn`=0x00500093 next cycle, `count` 1 then 0.
- Back-to-back ADD(3,1,2), LUI(5, 0x12345000), SD(rs1=1, rs2=2, imm=8, mode64=1) → 0x002081b3, 0x123452b7, 0x0020b423 in order, no bubbles.
- BEQ(0,0,+8), JAL(rd=1,+8), EBREAK with `out_ready`=0 until full → 0x00000463, 0x008000ef, 0x00100073 drained in order.
  - `in_ready`=0 once `count`=4, including when `out_ready`=1 and a push is attempted while full.
- Illegal requests:
  - ADDI imm=2048 → no FIFO write, `enc_err` pulses one cycle.
  - BEQ imm=3 → same.
  - SLLI imm=40 with `mode64`=0 → same.
  - SLLI imm=40 with `mode64`=1 → accepted.
- Flush and reset:
  - FIFO holding 3 words, assert `flush` with `in_valid`=1 → next cycle `count`=0, `out_valid`=0, pushed word absent.
  - Repeat with `reset` → identical outcome, `enc_err`=0.

Source files
------------

// File: rtl/rv_enc_pkg.sv
// rv_enc_pkg: shared op enum, opcode/funct constants and immediate-range helper for the RISC-V encoder.
package rv_enc_pkg;
  typedef enum logic [4:0] {
    OP_LUI, OP_AUIPC, OP_ADDI, OP_SLLI, OP_SRLI, OP_SRAI, OP_ADD, OP_SUB, OP_LW,
    OP_LD, OP_SW, OP_SD, OP_BEQ, OP_BNE, OP_JAL, OP_JALR, OP_EBREAK, OP_RDCYCLE
  } enc_op_t;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6f;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;
  localparam logic [2:0] F3_ADD = 3'd0;
  localparam logic [2:0] F3_SLL = 3'd1;
  localparam logic [2:0] F3_SR  = 3'd5;
  localparam logic [2:0] F3_W   = 3'd2;
  localparam logic [2:0] F3_D   = 3'd3;
  localparam logic [2:0] F3_BEQ = 3'd0;
  localparam logic [2:0] F3_BNE = 3'd1;
  localparam logic [2:0] F3_CSRRS = 3'd2;
  localparam logic [6:0] F7_ADD = 7'h00;
  localparam logic [6:0] F7_SUB = 7'h20;
  localparam logic [11:0] CSR_CYCLE = 12'hc00;
  function automatic logic fits_s(input logic [31:0] v, input int n);
    int s;
    s = $signed(v);
    return (s >= -(1 <<< (n - 1))) && (s < (1 <<< (n - 1)));
  endfunction
endpackage

// File: rtl/rv_enc_core.sv
// rv_enc_core: combinational encoder from structured request to 32-bit RISC-V word with legality check.
module rv_enc_core
  import rv_enc_pkg::*;
(
  input  enc_op_t     op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  input  logic        mode64,
  output logic [31:0] insn,
  output logic        illegal
);
  always_comb begin
    insn = '0;
    illegal = 1'b0;
    case (op)
      OP_LUI, OP_AUIPC: begin
        insn = {imm[31:12], rd, op == OP_LUI ? OPC_LUI : OPC_AUIPC};
        illegal = imm[11:0] != 12'd0;
      end
      OP_ADDI: begin
        insn = {imm[11:0], rs1, F3_ADD, rd, OPC_OPIMM};
        illegal = !fits_s(imm, 12);
      end
      OP_SLLI, OP_SRLI, OP_SRAI: begin
        // bit 30 distinguishes arithmetic from logical right shift
        insn = {1'b0, op == OP_SRAI, 4'b0, imm[5:0], rs1, op == OP_SLLI ? F3_SLL : F3_SR, rd, OPC_OPIMM};
        illegal = mode64 ? imm[31:6] != 26'd0 : imm[31:5] != 27'd0;
      end
      OP_ADD, OP_SUB: insn = {op == OP_SUB ? F7_SUB : F7_ADD, rs2, rs1, F3_ADD, rd, OPC_OP};
      OP_LW, OP_LD: begin
        insn = {imm[11:0], rs1, op == OP_LD ? F3_D : F3_W, rd, OPC_LOAD};
        illegal = !fits_s(imm, 12) || (op == OP_LD && !mode64);
      end
      OP_SW, OP_SD: begin
        insn = {imm[11:5], rs2, rs1, op == OP_SD ? F3_D : F3_W, imm[4:0], OPC_STORE};
        illegal = !fits_s(imm, 12) || (op == OP_SD && !mode64);
      end
      OP_BEQ, OP_BNE: begin
        insn = {imm[12], imm[10:5], rs2, rs1, op == OP_BNE ? F3_BNE : F3_BEQ, imm[4:1], imm[11], OPC_BRANCH};
        illegal = !fits_s(imm, 13) || imm[0];
      end
      OP_JAL: begin
        insn = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
        illegal = !fits_s(imm, 21) || imm[0];
      end
      OP_JALR: begin
        insn = {imm[11:0], rs1, 3'b000, rd, OPC_JALR};
        illegal = !fits_s(imm, 12);
      end
      OP_EBREAK: insn = {12'h001, 5'd0, 3'b000, 5'd0, OPC_SYSTEM};
      OP_RDCYCLE: insn = {CSR_CYCLE, 5'd0, F3_CSRRS, rd, OPC_SYSTEM};
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/rv_insn_encode.sv
// rv_insn_encode: range-checks and encodes requests, queues words in a small FIFO drained by valid/ready.
module rv_insn_encode
  import rv_enc_pkg::*;
#(
  parameter int LG_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mode64,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  enc_op_t           in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_insn,
  output logic              enc_err,
  output logic [LG_DEPTH:0] count
);
  localparam int DEPTH = 1 << LG_DEPTH;
  localparam logic [LG_DEPTH:0] ONE = 1;
  logic [31:0] mem [DEPTH];
  logic [LG_DEPTH:0] wr_ptr, rd_ptr;
  logic [31:0] insn;
  logic illegal, full, empty, accept, push, pop;
  rv_enc_core core (
    .op(in_op), .rd(in_rd), .rs1(in_rs1), .rs2(in_rs2), .imm(in_imm),
    .mode64(mode64), .insn(insn), .illegal(illegal)
  );
  assign full = (wr_ptr[LG_DEPTH] != rd_ptr[LG_DEPTH]) && (wr_ptr[LG_DEPTH-1:0] == rd_ptr[LG_DEPTH-1:0]);
  assign empty = wr_ptr == rd_ptr;
  assign in_ready = !full && !flush && !reset;
  assign accept = in_valid && in_ready;
  assign push = accept && !illegal;
  assign pop = out_valid && out_ready;
  assign out_valid = !empty;
  assign out_insn = mem[rd_ptr[LG_DEPTH-1:0]];
  assign count = wr_ptr - rd_ptr;
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      enc_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      enc_err <= accept && illegal;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) begin
          mem[wr_ptr[LG_DEPTH-1:0]] <= insn;
          wr_ptr <= wr_ptr + ONE;
        end
        if (pop) rd_ptr <= rd_ptr + ONE;
      end
    end
  end
endmodule

// File: tb/tb_rv_insn_encode.sv
// tb_rv_insn_encode: directed vectors with hand-computed instruction words for rv_insn_encode.
module tb_rv_insn_encode;
  import rv_enc_pkg::*;
  logic clk = 0, reset = 1, mode64 = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, enc_err;
  enc_op_t in_op = OP_ADDI;
  logic [4:0] in_rd = 0, in_rs1 = 0, in_rs2 = 0;
  logic [31:0] in_imm = 0, out_insn;
  logic [2:0] count;
  int total = 0, bad = 0;
  rv_insn_encode dut (
    .clk(clk), .reset(reset), .mode64(mode64), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready), .out_insn(out_insn),
    .enc_err(enc_err), .count(count)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic req(input enc_op_t op, input logic [4:0] rd, rs1, rs2, input logic [31:0] imm);
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_valid = 1;
  endtask
  task automatic push1(input enc_op_t op, input logic [4:0] rd, rs1, rs2, input logic [31:0] imm);
    req(op, rd, rs1, rs2, imm);
    tick();
    in_valid = 0;
  endtask
  initial begin
    tick(); tick();
    reset = 0;
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_err", 32'(enc_err), 0);
    chk("rst_insn", out_insn, 0);
    chk("rst_ready", 32'(in_ready), 1);
    // single ADDI, one-cycle latency
    out_ready = 1;
    req(OP_ADDI, 1, 0, 7, 5);
    tick();
    in_valid = 0;
    chk("addi_insn", out_insn, 32'h00500093);
    chk("addi_valid", 32'(out_valid), 1);
    chk("addi_cnt1", 32'(count), 1);
    tick();
    chk("addi_cnt0", 32'(count), 0);
    chk("addi_empty", 32'(out_valid), 0);
    // back-to-back stream, no bubbles
    mode64 = 1;
    req(OP_ADD, 3, 1, 2, 32'hfff);
    tick();
    chk("b2b_add", out_insn, 32'h002081b3);
    req(OP_LUI, 5, 9, 9, 32'h12345000);
    tick();
    chk("b2b_lui", out_insn, 32'h123452b7);
    chk("b2b_cnt", 32'(count), 1);
    req(OP_SD, 9, 1, 2, 8);
    tick();
    chk("b2b_sd", out_insn, 32'h0020b423);
    chk("b2b_valid", 32'(out_valid), 1);
    in_valid = 0;
    tick();
    chk("b2b_drained", 32'(count), 0);
    // fill to full with consumer stalled
    out_ready = 0;
    push1(OP_BEQ, 0, 0, 0, 8);
    push1(OP_JAL, 1, 3, 3, 8);
    push1(OP_EBREAK, 4, 4, 4, 32'h55);
    push1(OP_ADDI, 1, 0, 0, 5);
    chk("full_cnt", 32'(count), 4);
    chk("full_ready", 32'(in_ready), 0);
    out_ready = 1;
    req(OP_LUI, 5, 0, 0, 32'h12345000);
    #1;
    chk("full_ready_pop", 32'(in_ready), 0);
    chk("full_head", out_insn, 32'h00000463);
    tick();
    in_valid = 0;
    chk("drain_cnt3", 32'(count), 3);
    chk("drain_jal", out_insn, 32'h008000ef);
    tick();
    chk("drain_ebreak", out_insn, 32'h00100073);
    tick();
    chk("drain_addi", out_insn, 32'h00500093);
    tick();
    chk("drain_empty", 32'(out_valid), 0);
    chk("drain_cnt0", 32'(count), 0);
    // illegal requests pulse enc_err and write nothing
    mode64 = 0;
    push1(OP_ADDI, 1, 0, 0, 2048);
    chk("ill_addi_err", 32'(enc_err), 1);
    chk("ill_addi_cnt", 32'(count), 0);
    tick();
    chk("ill_addi_pulse", 32'(enc_err), 0);
    push1(OP_BEQ, 0, 1, 2, 3);
    chk("ill_beq_err", 32'(enc_err), 1);
    chk("ill_beq_valid", 32'(out_valid), 0);
    tick();
    chk("ill_beq_pulse", 32'(enc_err), 0);
    push1(OP_SLLI, 1, 2, 0, 40);
    chk("ill_slli_err", 32'(enc_err), 1);
    chk("ill_slli_cnt", 32'(count), 0);
    tick();
    chk("ill_slli_pulse", 32'(enc_err), 0);
    mode64 = 1;
    out_ready = 0;
    push1(OP_SLLI, 1, 2, 0, 40);
    chk("slli64_err", 32'(enc_err), 0);
    chk("slli64_insn", out_insn, 32'h02811093);
    chk("slli64_cnt", 32'(count), 1);
    out_ready = 1;
    tick();
    out_ready = 0;
    // flush with a concurrent push
    push1(OP_ADD, 3, 1, 2, 0);
    push1(OP_ADD, 3, 1, 2, 0);
    push1(OP_ADD, 3, 1, 2, 0);
    chk("fl_pre_cnt", 32'(count), 3);
    flush = 1;
    req(OP_ADDI, 1, 0, 0, 5);
    #1;
    chk("fl_ready", 32'(in_ready), 0);
    tick();
    flush = 0;
    in_valid = 0;
    chk("fl_cnt", 32'(count), 0);
    chk("fl_valid", 32'(out_valid), 0);
    tick();
    chk("fl_absent", 32'(count), 0);
    // reset mid-stream with an illegal request on the input
    push1(OP_LUI, 5, 0, 0, 32'h12345000);
    push1(OP_LUI, 5, 0, 0, 32'h12345000);
    push1(OP_LUI, 5, 0, 0, 32'h12345000);
    chk("rs_pre_cnt", 32'(count), 3);
    reset = 1;
    req(OP_ADDI, 1, 0, 0, 2048);
    tick();
    reset = 0;
    in_valid = 0;
    chk("rs_cnt", 32'(count), 0);
    chk("rs_valid", 32'(out_valid), 0);
    chk("rs_err", 32'(enc_err), 0);
    chk("rs_insn", out_insn, 0);
    tick();
    chk("rs_absent", 32'(count), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
